multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: Moore FSM with registered control outputs,
// plus the memory-handshake gating of irwrite/pcwrite in FETCH and the DECODE illegal-op pulse.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchne,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        ADDIEX  = 4'd10,
        SLTIEX  = 4'd11,
        ORIEX   = 4'd12,
        IMMWB   = 4'd13,
        JEX     = 4'd14
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       fetch;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       decode;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    function automatic logic is_legal_op(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_SLTI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    state_e state_r;
    state_e next_state_s;
    logic   run_r;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_s;

    // State register; run_r holds FETCH for the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
            run_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            run_r   <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = FETCH;
        if (!run_r) begin
            next_state_s = FETCH;
        end else begin
            case (state_r)
                FETCH:   next_state_s = memready ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: next_state_s = MEMADR;
                        OP_RTYPE:     next_state_s = RTYPEEX;
                        OP_BEQ:       next_state_s = BEQEX;
                        OP_BNE:       next_state_s = BNEEX;
                        OP_ADDI:      next_state_s = ADDIEX;
                        OP_SLTI:      next_state_s = SLTIEX;
                        OP_ORI:       next_state_s = ORIEX;
                        OP_J:         next_state_s = JEX;
                        default:      next_state_s = FETCH;
                    endcase
                end
                MEMADR:  next_state_s = (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   next_state_s = memready ? MEMWB : MEMRD;
                MEMWB:   next_state_s = FETCH;
                MEMWR:   next_state_s = memready ? FETCH : MEMWR;
                RTYPEEX: next_state_s = RTYPEWB;
                RTYPEWB: next_state_s = FETCH;
                BEQEX:   next_state_s = FETCH;
                BNEEX:   next_state_s = FETCH;
                ADDIEX:  next_state_s = IMMWB;
                SLTIEX:  next_state_s = IMMWB;
                ORIEX:   next_state_s = IMMWB;
                IMMWB:   next_state_s = FETCH;
                JEX:     next_state_s = FETCH;
                default: next_state_s = FETCH;
            endcase
        end
    end

    // Output decode of the state being entered, so the registered outputs track state_r
    always_comb begin
        ctrl_s = '0;
        case (next_state_s)
            FETCH: begin
                ctrl_s.memread = 1'b1;
                ctrl_s.fetch   = 1'b1;
                ctrl_s.alusrcb = 2'b01;
            end
            DECODE: begin
                ctrl_s.alusrcb = 2'b11;
                ctrl_s.decode  = 1'b1;
            end
            MEMADR: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
            end
            MEMRD: begin
                ctrl_s.iord    = 1'b1;
                ctrl_s.memread = 1'b1;
            end
            MEMWB: begin
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_s.iord     = 1'b1;
                ctrl_s.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = 3'b010;
            end
            RTYPEWB: begin
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = 3'b001;
                ctrl_s.branch  = 1'b1;
                ctrl_s.pcsrc   = 2'b01;
            end
            BNEEX: begin
                ctrl_s.alusrca  = 1'b1;
                ctrl_s.aluop    = 3'b100;
                ctrl_s.branchne = 1'b1;
                ctrl_s.pcsrc    = 2'b01;
            end
            ADDIEX, SLTIEX, ORIEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
                if (next_state_s == SLTIEX) begin
                    ctrl_s.aluop = 3'b011;
                end else if (next_state_s == ORIEX) begin
                    ctrl_s.aluop = 3'b110;
                end else begin
                    ctrl_s.aluop = 3'b000;
                end
            end
            IMMWB: begin
                ctrl_s.regwrite = 1'b1;
            end
            JEX: begin
                ctrl_s.pcsrc   = 2'b10;
                ctrl_s.pcwrite = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Control output register, cleared immediately by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r <= '0;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    // irwrite/pcwrite in FETCH and illegal in DECODE are qualified by live inputs
    assign pcwrite  = ctrl_r.pcwrite | (ctrl_r.fetch & memready);
    assign irwrite  = ctrl_r.fetch & memready;
    assign illegal  = ctrl_r.decode & ~is_legal_op(op);
    assign branch   = ctrl_r.branch;
    assign branchne = ctrl_r.branchne;
    assign iord     = ctrl_r.iord;
    assign memread  = ctrl_r.memread;
    assign memwrite = ctrl_r.memwrite;
    assign memtoreg = ctrl_r.memtoreg;
    assign regdst   = ctrl_r.regdst;
    assign regwrite = ctrl_r.regwrite;
    assign alusrca  = ctrl_r.alusrca;
    assign alusrcb  = ctrl_r.alusrcb;
    assign pcsrc    = ctrl_r.pcsrc;
    assign aluop    = ctrl_r.aluop;
    assign state    = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every output is packed into one word and
// compared each cycle against hand-written per-state expectations.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       memready;
    logic       pcwrite, branch, branchne, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .memready (memready),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .branchne (branchne),
        .iord     (iord),
        .memread  (memread),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .illegal  (illegal),
        .state    (state)
    );

    // Field order: pcwrite branch branchne iord memread memwrite irwrite memtoreg
    // regdst regwrite alusrca | alusrcb | pcsrc | aluop | illegal | state
    logic [22:0] obs;
    assign obs = {pcwrite, branch, branchne, iord, memread, memwrite, irwrite, memtoreg,
                  regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal, state};

    localparam logic [22:0] E_ZERO       = 23'd0;
    localparam logic [22:0] E_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 4'd0};
    localparam logic [22:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 4'd0};
    localparam logic [22:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 2'b00, 3'b000, 1'b0, 4'd1};
    localparam logic [22:0] E_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 2'b00, 3'b000, 1'b1, 4'd1};
    localparam logic [22:0] E_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 3'b000, 1'b0, 4'd2};
    localparam logic [22:0] E_MEMRD      = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 4'd3};
    localparam logic [22:0] E_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 4'd4};
    localparam logic [22:0] E_MEMWR      = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 4'd5};
    localparam logic [22:0] E_RTEX       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 3'b010, 1'b0, 4'd6};
    localparam logic [22:0] E_RTWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 4'd7};
    localparam logic [22:0] E_BEQ        = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b01, 3'b001, 1'b0, 4'd8};
    localparam logic [22:0] E_BNE        = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b01, 3'b100, 1'b0, 4'd9};
    localparam logic [22:0] E_SLTI       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 3'b011, 1'b0, 4'd11};
    localparam logic [22:0] E_ORI        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 3'b110, 1'b0, 4'd12};
    localparam logic [22:0] E_IMMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 4'd13};
    localparam logic [22:0] E_JEX        = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b10, 3'b000, 1'b0, 4'd14};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [22:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expected);
        end
    endtask

    // One cycle: drive inputs mid-cycle, then compare the current state's outputs
    task automatic cyc(input logic [5:0] op_v, input logic mr_v, input logic [22:0] expected,
                       input string tag);
        @(negedge clk);
        op       = op_v;
        memready = mr_v;
        #1;
        check(tag, expected);
    endtask

    initial begin
        reset_n  = 1'b0;
        op       = 6'b000000;
        memready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_hold", E_ZERO);

        // Release with memready high: the first edge must still land in FETCH
        @(negedge clk);
        reset_n = 1'b1;

        // lw, no waits: 5 cycles
        cyc(6'b100011, 1'b1, E_FETCH_RDY, "lw_fetch");
        cyc(6'b100011, 1'b1, E_DECODE,    "lw_decode");
        cyc(6'b100011, 1'b1, E_MEMADR,    "lw_memadr");
        cyc(6'b100011, 1'b1, E_MEMRD,     "lw_memrd");
        cyc(6'b100011, 1'b1, E_MEMWB,     "lw_memwb");

        // sw with 3 wait cycles; op changes during MEMWR must be ignored
        cyc(6'b101011, 1'b1, E_FETCH_RDY, "sw_fetch");
        cyc(6'b101011, 1'b1, E_DECODE,    "sw_decode");
        cyc(6'b101011, 1'b1, E_MEMADR,    "sw_memadr");
        cyc(6'b000000, 1'b0, E_MEMWR,     "sw_wr1");
        cyc(6'b000100, 1'b0, E_MEMWR,     "sw_wr2");
        cyc(6'b100011, 1'b0, E_MEMWR,     "sw_wr3");
        cyc(6'b000000, 1'b1, E_MEMWR,     "sw_wr4");

        // R-type, preceded by one FETCH wait cycle
        cyc(6'b000000, 1'b0, E_FETCH_WAIT, "rt_fetch_wait");
        cyc(6'b000000, 1'b1, E_FETCH_RDY,  "rt_fetch");
        cyc(6'b000000, 1'b1, E_DECODE,     "rt_decode");
        cyc(6'b000000, 1'b1, E_RTEX,       "rt_ex");
        cyc(6'b000000, 1'b1, E_RTWB,       "rt_wb");

        // beq then bne
        cyc(6'b000100, 1'b1, E_FETCH_RDY, "beq_fetch");
        cyc(6'b000100, 1'b1, E_DECODE,    "beq_decode");
        cyc(6'b000100, 1'b1, E_BEQ,       "beq_ex");
        cyc(6'b000101, 1'b1, E_FETCH_RDY, "bne_fetch");
        cyc(6'b000101, 1'b1, E_DECODE,    "bne_decode");
        cyc(6'b000101, 1'b1, E_BNE,       "bne_ex");

        // slti and ori
        cyc(6'b001010, 1'b1, E_FETCH_RDY, "slti_fetch");
        cyc(6'b001010, 1'b1, E_DECODE,    "slti_decode");
        cyc(6'b001010, 1'b1, E_SLTI,      "slti_ex");
        cyc(6'b001010, 1'b1, E_IMMWB,     "slti_wb");
        cyc(6'b001101, 1'b1, E_FETCH_RDY, "ori_fetch");
        cyc(6'b001101, 1'b1, E_DECODE,    "ori_decode");
        cyc(6'b001101, 1'b1, E_ORI,       "ori_ex");
        cyc(6'b001101, 1'b1, E_IMMWB,     "ori_wb");

        // jump
        cyc(6'b000010, 1'b1, E_FETCH_RDY, "j_fetch");
        cyc(6'b000010, 1'b1, E_DECODE,    "j_decode");
        cyc(6'b000010, 1'b1, E_JEX,       "j_ex");

        // illegal opcode: one-cycle pulse in DECODE, back to FETCH
        cyc(6'b111111, 1'b1, E_FETCH_RDY,  "ill_fetch");
        cyc(6'b111111, 1'b1, E_DECODE_ILL, "ill_decode");
        cyc(6'b111111, 1'b1, E_FETCH_RDY,  "ill_back_fetch");

        // Reset asserted during a MEMRD wait aborts at once
        cyc(6'b100011, 1'b1, E_DECODE, "ab_decode");
        cyc(6'b100011, 1'b1, E_MEMADR, "ab_memadr");
        cyc(6'b100011, 1'b0, E_MEMRD,  "ab_memrd_wait");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ab_async_zero", E_ZERO);
        memready = 1'b1;
        @(negedge clk);
        #1;
        check("ab_held_zero", E_ZERO);
        reset_n = 1'b1;
        cyc(6'b100011, 1'b1, E_FETCH_RDY, "ab_release_fetch");
        cyc(6'b100011, 1'b1, E_DECODE,    "ab_release_decode");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
